riscv_cache_biu_seq: RTL and testbench

//  Bus-side burst sequencer directly downstream of the cache BIU controller.

---
 rtl/riscv_cache_biu_seq_if.sv | 89 ++++++++
 rtl/riscv_cache_biu_seq.sv | 175 +++++++++++++++++
 tb/tb_riscv_cache_biu_seq.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_cache_biu_seq_if.sv
// ---------------------------------------------------------------------------
// riscv_cache_biu_seq_pkg / riscv_cache_biu_seq_if
//
// Purpose
//   Shared transfer-size and burst-type encodings, plus the bus bundle that
//   connects the burst sequencer to the BIU controller above it and to the
//   memory port below it.
//
// Signals (directions as seen by the sequencer)
//   biu_stb_i/biu_stb_ack_o      transfer request / same-cycle accept
//   biu_adri_i, biu_size_i,
//   biu_type_i, biu_we_i         transfer attributes, sampled on accept
//   biu_d_i/biu_d_ack_o          write data, next beat taken on d_ack
//   biu_q_o, biu_adro_o          read data and address of the acked beat
//   biu_ack_o/biu_err_o          per-beat completion / error
//   mem_req_o ... mem_d_o        per-beat request towards memory
//   mem_gnt_i, mem_rvalid_i,
//   mem_q_i, mem_err_i           memory grant and response
//
// Modports
//   slave  : the sequencer (serves transfers, drives the memory request)
//   master : the environment (BIU controller and memory side)
// ---------------------------------------------------------------------------
package riscv_cache_biu_seq_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } biu_type_t;

endpackage

interface riscv_cache_biu_seq_if #(
    parameter int XLEN = 32,
    parameter int PLEN = XLEN
) ();
    import riscv_cache_biu_seq_pkg::*;

    logic              biu_stb_i;
    logic              biu_stb_ack_o;
    logic              biu_d_ack_o;
    logic [PLEN-1:0]   biu_adri_i;
    logic [PLEN-1:0]   biu_adro_o;
    biu_size_t         biu_size_i;
    biu_type_t         biu_type_i;
    logic              biu_we_i;
    logic [XLEN-1:0]   biu_d_i;
    logic [XLEN-1:0]   biu_q_o;
    logic              biu_ack_o;
    logic              biu_err_o;

    logic              mem_req_o;
    logic [PLEN-1:0]   mem_adr_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_d_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_q_i;
    logic              mem_err_i;

    modport slave (
        input  biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_we_i, biu_d_i,
        output biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
        output mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o,
        input  mem_gnt_i, mem_rvalid_i, mem_q_i, mem_err_i
    );

    modport master (
        output biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_we_i, biu_d_i,
        input  biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
        input  mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o,
        output mem_gnt_i, mem_rvalid_i, mem_q_i, mem_err_i
    );

endinterface

// File: rtl/riscv_cache_biu_seq.sv
// ---------------------------------------------------------------------------
// riscv_cache_biu_seq
//
// Purpose
//   Burst sequencer below the cache BIU controller. One transfer (SINGLE,
//   INCR, WRAPx, INCRx) is accepted from the biu_* side and replayed as a
//   series of single beats on a req/gnt/rvalid memory port, with at most one
//   beat outstanding. Each completed beat is reported upstream with ack or
//   err, the read data and the beat address.
//
// Ports
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   bus      riscv_cache_biu_seq_if.slave (BIU strobe side + memory port)
// ---------------------------------------------------------------------------
module riscv_cache_biu_seq
    import riscv_cache_biu_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = XLEN
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    riscv_cache_biu_seq_if.slave bus
);

    localparam int BEAT = XLEN / 8;
    localparam int BW   = $clog2(BEAT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state_q, state_d;
    logic [PLEN-1:0] adr_q,   adr_d;
    logic            we_q,    we_d;
    biu_type_t       type_q,  type_d;
    logic [XLEN-1:0] dat_q,   dat_d;
    logic [BEAT-1:0] be_q,    be_d;
    logic [3:0]      cnt_q,   cnt_d;

    // Number of beats minus one for a given burst type.
    function automatic logic [3:0] len_m1(input biu_type_t t);
        case (t)
            WRAP4, INCR4:   len_m1 = 4'd3;
            WRAP8, INCR8:   len_m1 = 4'd7;
            WRAP16, INCR16: len_m1 = 4'd15;
            default:        len_m1 = 4'd0;
        endcase
    endfunction

    // Byte-lane mask of the wrap window (len * beat bytes, minus one);
    // zero means the burst increments linearly.
    function automatic logic [PLEN-1:0] wrap_mask(input biu_type_t t);
        case (t)
            WRAP4:   wrap_mask = PLEN'(4 * BEAT - 1);
            WRAP8:   wrap_mask = PLEN'(8 * BEAT - 1);
            WRAP16:  wrap_mask = PLEN'(16 * BEAT - 1);
            default: wrap_mask = '0;
        endcase
    endfunction

    // Lanes for a single-beat access; misaligned size/address pairs are not
    // detected, the mask is simply shifted by the low address bits.
    function automatic logic [BEAT-1:0] lane_mask(input biu_size_t s,
                                                  input logic [BW-1:0] lo);
        logic [BEAT-1:0] m;
        case (s)
            BYTE:    m = BEAT'(1);
            HWORD:   m = BEAT'(3);
            WORD:    m = BEAT'(15);
            default: m = '1;
        endcase
        if (s == DWORD) lane_mask = '1;
        else            lane_mask = m << lo;
    endfunction

    logic [PLEN-1:0] wmask;
    logic [PLEN-1:0] adr_inc;
    logic [PLEN-1:0] adr_next;

    // Address of the following beat: linear step, or step folded back into
    // the aligned wrap window while the upper address bits stay untouched.
    always_comb begin
        wmask    = wrap_mask(type_q);
        adr_inc  = adr_q + PLEN'(BEAT);
        adr_next = adr_inc;
        if (wmask != '0) adr_next = (adr_q & ~wmask) | (adr_inc & wmask);
    end

    // Next-state and output decode. Requests are only taken in IDLE; a beat
    // response in DATA either finishes the transfer (last beat or error) or
    // advances to the next beat, pulling the next write word on the way.
    always_comb begin
        state_d           = state_q;
        adr_d             = adr_q;
        we_d              = we_q;
        type_d            = type_q;
        dat_d             = dat_q;
        be_d              = be_q;
        cnt_d             = cnt_q;
        bus.biu_stb_ack_o = 1'b0;
        bus.biu_d_ack_o   = 1'b0;
        bus.biu_ack_o     = 1'b0;
        bus.biu_err_o     = 1'b0;
        bus.biu_q_o       = '0;
        bus.mem_req_o     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.biu_stb_ack_o = bus.biu_stb_i;
                if (bus.biu_stb_i) begin
                    adr_d   = bus.biu_adri_i;
                    we_d    = bus.biu_we_i;
                    type_d  = bus.biu_type_i;
                    dat_d   = bus.biu_d_i;
                    cnt_d   = len_m1(bus.biu_type_i);
                    be_d    = (len_m1(bus.biu_type_i) == 4'd0)
                            ? lane_mask(bus.biu_size_i, bus.biu_adri_i[BW-1:0])
                            : '1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.mem_req_o = 1'b1;
                if (bus.mem_gnt_i) state_d = DATA;
            end
            DATA: begin
                if (bus.mem_rvalid_i) begin
                    bus.biu_ack_o = ~bus.mem_err_i;
                    bus.biu_err_o = bus.mem_err_i;
                    bus.biu_q_o   = bus.mem_q_i;
                    if (bus.mem_err_i || cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        adr_d   = adr_next;
                        state_d = ADDR;
                        if (we_q) begin
                            bus.biu_d_ack_o = 1'b1;
                            dat_d           = bus.biu_d_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_adr_o  = adr_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_be_o   = be_q;
    assign bus.mem_d_o    = dat_q;
    assign bus.biu_adro_o = adr_q;

    // State and beat registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            type_q  <= SINGLE;
            dat_q   <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            type_q  <= type_d;
            dat_q   <= dat_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_cache_biu_seq.sv
// ---------------------------------------------------------------------------
// tb_riscv_cache_biu_seq
//
// Purpose
//   Directed bench for the burst sequencer. Stimulus pushes the hand-derived
//   memory beats and upstream responses it expects into queues; a monitor
//   running on the falling edge pops and compares whenever the DUT requests
//   a beat or reports one. A small memory model supplies grant delay, read
//   data and error injection.
// ---------------------------------------------------------------------------
module tb_riscv_cache_biu_seq;
    import riscv_cache_biu_seq_pkg::*;

    localparam int XLEN = 32;
    localparam int PLEN = 32;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
    } mem_exp_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] q;
        logic [31:0] adro;
    } resp_exp_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int acc_cyc      = 0;
    int last_ack_cyc = 0;
    int d_ack_cnt    = 0;
    int gnt_wait     = 0;
    int gnt_delay    = 0;
    int wr_ptr       = 0;
    logic        err_en  = 1'b0;
    logic [31:0] err_adr = '0;
    logic        rv_q    = 1'b0;
    logic        er_q    = 1'b0;
    logic [31:0] rd_q    = '0;

    always #5 clk = ~clk;

    riscv_cache_biu_seq_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

    riscv_cache_biu_seq #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Read data the memory model returns for an address.
    function automatic logic [31:0] f_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Write word number i presented on biu_d_i.
    function automatic logic [31:0] wdat(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    // Memory model: grant after gnt_delay waiting cycles, respond one cycle
    // after the grant, flag an error for the beat at err_adr.
    assign bus.mem_gnt_i    = bus.mem_req_o && (gnt_wait >= gnt_delay);
    assign bus.mem_rvalid_i = rv_q;
    assign bus.mem_q_i      = rv_q ? rd_q : '0;
    assign bus.mem_err_i    = rv_q && er_q;

    always @(posedge clk) begin
        if (bus.mem_req_o && !bus.mem_gnt_i) gnt_wait <= gnt_wait + 1;
        else                                 gnt_wait <= 0;
        rv_q <= bus.mem_req_o && bus.mem_gnt_i;
        rd_q <= f_rd(bus.mem_adr_o);
        er_q <= err_en && (bus.mem_adr_o == err_adr);
    end

    // Write data source: one word consumed per write accept and per d_ack.
    assign bus.biu_d_i = wdat(wr_ptr);

    always @(posedge clk) begin
        if ((bus.biu_stb_i && bus.biu_stb_ack_o && bus.biu_we_i) || bus.biu_d_ack_o)
            wr_ptr <= wr_ptr + 1;
    end

    task automatic report_fail(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got 0x%0h, nothing was expected", name, act);
    endtask

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] adr, input logic we,
                            input logic [3:0] be, input logic [31:0] d);
        mem_exp_t e;
        e.adr = adr; e.we = we; e.be = be; e.d = d;
        exp_mem.push_back(e);
    endtask

    task automatic push_resp(input logic [31:0] adr, input logic err);
        resp_exp_t r;
        r.ack = !err; r.err = err; r.q = f_rd(adr); r.adro = adr;
        exp_resp.push_back(r);
    endtask

    task automatic expect_beat(input logic [31:0] adr, input logic we,
                               input logic [3:0] be, input logic [31:0] d,
                               input logic err);
        push_mem(adr, we, be, d);
        push_resp(adr, err);
    endtask

    // Monitor: every request cycle is compared to the head of the beat queue
    // (so the request must also hold steady until granted); every ack/err is
    // compared to the head of the response queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.biu_stb_i && bus.biu_stb_ack_o) acc_cyc = cyc;
            if (bus.biu_d_ack_o) d_ack_cnt++;
            if (bus.mem_req_o) begin
                if (exp_mem.size() == 0) begin
                    report_fail("unexpected mem_req", 64'(bus.mem_adr_o));
                end else begin
                    check_output("mem_adr", 64'(bus.mem_adr_o), 64'(exp_mem[0].adr));
                    check_output("mem_we",  64'(bus.mem_we_o),  64'(exp_mem[0].we));
                    check_output("mem_be",  64'(bus.mem_be_o),  64'(exp_mem[0].be));
                    if (exp_mem[0].we)
                        check_output("mem_d", 64'(bus.mem_d_o), 64'(exp_mem[0].d));
                    if (bus.mem_gnt_i) void'(exp_mem.pop_front());
                end
            end
            if (bus.biu_ack_o || bus.biu_err_o) begin
                last_ack_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    report_fail("unexpected biu ack/err", 64'(bus.biu_adro_o));
                end else begin
                    check_output("biu_ack",  64'(bus.biu_ack_o),  64'(exp_resp[0].ack));
                    check_output("biu_err",  64'(bus.biu_err_o),  64'(exp_resp[0].err));
                    check_output("biu_q",    64'(bus.biu_q_o),    64'(exp_resp[0].q));
                    check_output("biu_adro", 64'(bus.biu_adro_o), 64'(exp_resp[0].adro));
                    void'(exp_resp.pop_front());
                end
            end
        end
    end

    // Present a request, wait (bounded) for its accept and check how many
    // cycles the strobe stayed unanswered. Returns just after the accept edge.
    task automatic apply_stimulus(input string name, input biu_type_t t,
                                  input biu_size_t s, input logic [31:0] adr,
                                  input logic we, input bit hold_stb,
                                  input int exp_wait);
        int w = 0;
        bus.biu_type_i = t;
        bus.biu_size_i = s;
        bus.biu_adri_i = adr;
        bus.biu_we_i   = we;
        bus.biu_stb_i  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.biu_stb_ack_o) break;
            w++;
            if (w > 100) begin
                report_fail({name, " accept timeout"}, 64'(w));
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold_stb) bus.biu_stb_i = 1'b0;
        check_output({name, " stb wait cycles"}, 64'(w), 64'(exp_wait));
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_mem.size() != 0 || exp_resp.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        check_output({name, " queues drained"},
                     64'(exp_mem.size() + exp_resp.size()), 64'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " mem_req"},    64'(bus.mem_req_o),     64'd0);
        check_output({name, " mem_adr"},    64'(bus.mem_adr_o),     64'd0);
        check_output({name, " mem_we"},     64'(bus.mem_we_o),      64'd0);
        check_output({name, " mem_be"},     64'(bus.mem_be_o),      64'd0);
        check_output({name, " mem_d"},      64'(bus.mem_d_o),       64'd0);
        check_output({name, " biu_adro"},   64'(bus.biu_adro_o),    64'd0);
        check_output({name, " biu_ack"},    64'(bus.biu_ack_o),     64'd0);
        check_output({name, " biu_err"},    64'(bus.biu_err_o),     64'd0);
        check_output({name, " biu_q"},      64'(bus.biu_q_o),       64'd0);
        check_output({name, " biu_d_ack"},  64'(bus.biu_d_ack_o),   64'd0);
        check_output({name, " stb_ack"},    64'(bus.biu_stb_ack_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] t1_adr [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    logic [31:0] t2_adr [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};

    initial begin
        int base;
        bus.biu_stb_i  = 1'b0;
        bus.biu_adri_i = '0;
        bus.biu_size_i = WORD;
        bus.biu_type_i = SINGLE;
        bus.biu_we_i   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] test 1: WRAP4 read at 0x1008");
        for (int k = 0; k < 4; k++) expect_beat(t1_adr[k], 1'b0, 4'hF, 32'h0, 1'b0);
        apply_stimulus("t1", WRAP4, WORD, 32'h1008, 1'b0, 1'b0, 0);
        drain("t1");
        check_output("t1 last ack offset", 64'(last_ack_cyc - acc_cyc), 64'd8);

        $display("[TB] test 2: WRAP4 write at 0x2000, grant delay 3");
        gnt_delay = 3;
        base = d_ack_cnt;
        for (int k = 0; k < 4; k++) expect_beat(t2_adr[k], 1'b1, 4'hF, wdat(k), 1'b0);
        apply_stimulus("t2", WRAP4, WORD, 32'h2000, 1'b1, 1'b0, 0);
        drain("t2");
        check_output("t2 d_ack pulses", 64'(d_ack_cnt - base), 64'd3);
        gnt_delay = 0;

        $display("[TB] test 3: SINGLE byte write at 0x3003, strobe held");
        base = d_ack_cnt;
        expect_beat(32'h3003, 1'b1, 4'b1000, wdat(4), 1'b0);
        expect_beat(32'h3100, 1'b0, 4'hF, 32'h0, 1'b0);
        apply_stimulus("t3a", SINGLE, BYTE, 32'h3003, 1'b1, 1'b1, 0);
        apply_stimulus("t3b", SINGLE, WORD, 32'h3100, 1'b0, 1'b0, 2);
        drain("t3");
        check_output("t3 d_ack pulses", 64'(d_ack_cnt - base), 64'd0);

        $display("[TB] test 4: INCR8 read at 0x40F8");
        for (int k = 0; k < 8; k++)
            expect_beat(32'h40F8 + 32'(4 * k), 1'b0, 4'hF, 32'h0, 1'b0);
        apply_stimulus("t4", INCR8, WORD, 32'h40F8, 1'b0, 1'b0, 0);
        drain("t4");

        $display("[TB] test 5: WRAP8 read at 0x5018, error on third beat");
        err_en  = 1'b1;
        err_adr = 32'h5000;
        expect_beat(32'h5018, 1'b0, 4'hF, 32'h0, 1'b0);
        expect_beat(32'h501C, 1'b0, 4'hF, 32'h0, 1'b0);
        expect_beat(32'h5000, 1'b0, 4'hF, 32'h0, 1'b1);
        apply_stimulus("t5", WRAP8, WORD, 32'h5018, 1'b0, 1'b0, 0);
        drain("t5");
        err_en = 1'b0;

        $display("[TB] test 6: reset during WRAP4 write at 0x6004");
        base = d_ack_cnt;
        push_mem(32'h6004, 1'b1, 4'hF, wdat(5));
        push_resp(32'h6004, 1'b0);
        push_mem(32'h6008, 1'b1, 4'hF, wdat(6));
        apply_stimulus("t6", WRAP4, WORD, 32'h6004, 1'b1, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("t6 reset");
        check_output("t6 d_ack pulses", 64'(d_ack_cnt - base), 64'd1);
        check_output("t6 beats before reset", 64'(exp_mem.size()), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        expect_beat(32'h7000, 1'b0, 4'hF, 32'h0, 1'b0);
        apply_stimulus("t6 after reset", SINGLE, WORD, 32'h7000, 1'b0, 1'b0, 0);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
